// File: rtl/ingress_flit_queue.sv
// First-word fall-through flit queue between the traffic generator and the NoC.
// Optional egress-id range check: define INGRESS_FLIT_QUEUE_EGRESS_CHECK_EN.
module ingress_flit_queue #(
   parameter int DEPTH        = 4,
   parameter int EGRESS_BITS  = 64,
   parameter int PAYLOAD_BITS = 64,
   parameter int NUM_EGRESSES = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic                       in_head,
   input  logic                       in_tail,
   input  logic [EGRESS_BITS-1:0]     in_egress_id,
   input  logic [PAYLOAD_BITS-1:0]    in_payload,
   output logic                       noc_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_head,
   output logic                       out_tail,
   output logic [EGRESS_BITS-1:0]     out_egress_id,
   output logic [PAYLOAD_BITS-1:0]    out_payload,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       framing_error
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int EW = 2 + EGRESS_BITS + PAYLOAD_BITS;

   typedef enum logic {IDLE, IN_PKT} state_e;

   logic [EW-1:0]          mem_q [DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   overflow_q, overflow_d;
   logic                   ferr_q, ferr_d;
   state_e                 state_q, state_d;
   logic [EGRESS_BITS-1:0] id_q, id_d;
   logic                   push, pop;
   logic                   egress_bad;
   logic [CW:0]            occ_in;

   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;
   assign push      = in_valid &&
                      (({1'b0, count_q} < (CW+1)'(DEPTH)) || pop);

   // Reserve one slot: the generator reacts to noc_ready a cycle late.
   assign occ_in    = {1'b0, count_q} + (CW+1)'(in_valid);
   assign noc_ready = !reset && (occ_in <= (CW+1)'(DEPTH-1));

   assign {out_head, out_tail, out_egress_id, out_payload} = mem_q[rd_ptr_q];
   assign count         = count_q;
   assign overflow      = overflow_q;
   assign framing_error = ferr_q;

`ifdef INGRESS_FLIT_QUEUE_EGRESS_CHECK_EN
   assign egress_bad = (in_egress_id >= EGRESS_BITS'(NUM_EGRESSES));
`else
   wire unused_num_egresses = (NUM_EGRESSES == 0);
   assign egress_bad = 1'b0;
`endif

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      if (pop && !push) count_d = count_q - 1'b1;
      if (in_valid && !push) overflow_d = 1'b1;
   end

   // Framing is checked only on flits that actually enter the queue.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      ferr_d  = ferr_q;
      if (push) begin
         unique case (state_q)
            IDLE: begin
               if (!in_head) begin
                  ferr_d = 1'b1;
               end else if (!in_tail) begin
                  state_d = IN_PKT;
                  id_d    = in_egress_id;
               end
            end
            IN_PKT: begin
               if (in_head) begin
                  ferr_d  = 1'b1;
                  id_d    = in_egress_id;
                  state_d = in_tail ? IDLE : IN_PKT;
               end else begin
                  if (in_egress_id != id_q) ferr_d = 1'b1;
                  if (in_tail) state_d = IDLE;
               end
            end
         endcase
         if (egress_bad) ferr_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         ferr_q     <= 1'b0;
         state_q    <= IDLE;
         id_q       <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         ferr_q     <= ferr_d;
         state_q    <= state_d;
         id_q       <= id_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_head, in_tail, in_egress_id, in_payload};
      end
   end

endmodule

// File: doc/ingress_flit_queue.md
Name: ingress_flit_queue

Overview:
- Sits directly downstream of the per-ingress DPI traffic-generator black box, between it and the NoC ingress port.
- Accepts the generator's registered flit stream (valid/head/tail/egress_id/payload) and buffers it in a small FIFO.
- Presents the buffered flits to the NoC with a ready/valid handshake.
- Generates the generator's noc_ready input with one-flit slack, because the generator reacts to noc_ready one cycle late. Also checks packet framing.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- EGRESS_BITS, 64, egress id width.
- PAYLOAD_BITS, 64, payload width.
- NUM_EGRESSES, 1, number of valid egress ids; used only by the optional check.

Ports:
- clock  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  flit from generator this cycle; no backpressure on this side.
- in_head  in  1  first flit of packet.
- in_tail  in  1  last flit of packet.
- in_egress_id  in  EGRESS_BITS  destination egress.
- in_payload  in  PAYLOAD_BITS  flit data.
- noc_ready  out  1  permission for the generator to emit a flit next cycle.
- out_valid  out  1  head-of-queue flit available.
- out_ready  in  1  NoC accepts flit.
- out_head  out  1  head-of-queue head bit.
- out_tail  out  1  head-of-queue tail bit.
- out_egress_id  out  EGRESS_BITS  head-of-queue egress id.
- out_payload  out  PAYLOAD_BITS  head-of-queue payload.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: a flit was dropped.
- framing_error  out  1  sticky: protocol violation seen.

Behaviour:
- Reset (async assert, sync release):
  - count=0, rd/wr pointers=0, overflow=0, framing_error=0, framing FSM=IDLE.
  - out_valid=0; noc_ready forced 0 while reset is high.
- FIFO:
  - First-word fall-through. out_valid = (count != 0); out_* driven from the read-pointer entry with zero latency.
  - Pop when out_valid & out_ready. Push when in_valid and (count < DEPTH or pop this cycle).
  - Pointers are log2(DEPTH) bits and wrap naturally. count updates +1 on push only, -1 on pop only, unchanged on both.
  - A push in the same cycle as a pop on an empty queue is written to storage. It is not bypassed: out_valid rises next cycle.
  - Full queue with in_valid and no pop: flit dropped, count unchanged, overflow set to 1 until reset.
- noc_ready:
  - Combinational: noc_ready = ((count + in_valid) <= DEPTH-1).
  - This reserves one slot for the flit the generator may emit next cycle. It ignores a same-cycle pop (conservative).
  - Consequence: a generator that honours noc_ready never causes overflow.
- Framing FSM, evaluated on every accepted push (dropped flits are not checked):
  - IDLE:
    - head & tail: stay IDLE.
    - head & !tail: go to IN_PKT and latch egress_id.
    - !head: framing_error=1, stay IDLE.
  - IN_PKT:
    - head: framing_error=1, restart the packet (latch new id; IN_PKT, or IDLE if tail).
    - egress_id != latched id: framing_error=1.
    - tail: go to IDLE.
  - Flits are enqueued regardless of framing errors. framing_error is sticky until reset.
- Reset mid-packet: queue contents discarded, FSM returns to IDLE.
- Widths: count compare done at $clog2(DEPTH+1)+1 bits to avoid wrap.

Optional Feature:
- Macro INGRESS_FLIT_QUEUE_EGRESS_CHECK_EN.
- When defined: any accepted push with in_egress_id >= NUM_EGRESSES sets framing_error. The flit is still enqueued.
- When undefined: no range check; NUM_EGRESSES is unused. All other behaviour is identical.

Test Plan:
- Reset, then a single flit (head=1, tail=1, egress=0, payload=0xA5) with out_ready=1 -> out_valid high the next cycle with payload 0xA5; count returns to 0; no error flags.
- DEPTH=4, out_ready=0, generator pushes while honouring noc_ready -> count reaches 3 with noc_ready=0; at most one further flit brings count to 4; overflow stays 0.
- Full queue (count=4), in_valid=1, out_ready=0 -> flit dropped, overflow=1, count=4. Then with out_ready=1, 4 flits drain in original order.
- Full queue, simultaneous push and pop -> push accepted, count stays 4, FIFO order preserved across pointer wrap.
- Framing violations:
  - Push head=0 while IDLE -> framing_error=1.
  - After reset, packet head (egress 1) followed by body flit with egress 2 -> framing_error=1.
- With INGRESS_FLIT_QUEUE_EGRESS_CHECK_EN and NUM_EGRESSES=2, push egress 3 -> framing_error=1 and flit still delivered. Without the macro -> framing_error=0.
